// File: rtl/apb_slv_mem_pkg.sv
// Shared types and helpers for the APB slave memory.
// Optional protection checking is enabled by defining APB_SLV_MEM_PROT_CHK_EN.
package apb_slv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } apb_slv_state_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_RANGE = 2'd1,
        ERR_ALIGN = 2'd2,
        ERR_PROT  = 2'd3
    } apb_err_e;

    // Right-shift that turns a byte address into a word index.
    function automatic int word_shift(input int strb_width);
        return $clog2(strb_width);
    endfunction

endpackage

// File: rtl/apb_slv_mem_array.sv
// Word-addressed storage with byte-lane write enables and a registered read port.
// Contents are not reset; only the read register is.
module apb_slv_mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int DEPTH      = 256,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [STRB_WIDTH-1:0] wr_strb,
    input  logic                  rd_en,
    input  logic                  rd_clr,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_r;

    // Byte-lane writes into the storage array
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (wr_strb[i]) begin
                    mem_r[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Read register: cleared for errored/write responses, otherwise holds until next response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_r <= {DATA_WIDTH{1'b0}};
        end else if (rd_clr) begin
            rd_data_r <= {DATA_WIDTH{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_idx];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/apb_slv_mem.sv
// APB slave memory: FSM, wait counter, setup-phase latches and error decode.
// Define APB_SLV_MEM_PROT_CHK_EN to reject non-secure accesses to the upper half.
module apb_slv_mem
    import apb_slv_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic                  PWRITE,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [STRB_WIDTH-1:0] PSTROB,
    input  logic [2:0]            PPROT,
    output logic                  PREADY,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PSLVERR
);

    localparam int SHIFT  = word_shift(STRB_WIDTH);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int WORD_W = ADDR_WIDTH - SHIFT;

    apb_slv_state_e        state_r, state_s;
    logic [3:0]            cnt_r, cnt_s;
    logic                  pready_r, pready_s;
    logic                  pslverr_r, pslverr_s;
    logic [IDX_W-1:0]      idx_r;
    logic                  write_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [STRB_WIDTH-1:0] strb_r;
    apb_err_e              cause_r;

    logic [WORD_W-1:0]     word_s;
    apb_err_e              setup_cause_s;
    logic                  latch_s, wr_en_s, rd_en_s, rd_clr_s;
    logic [IDX_W-1:0]      rd_idx_s;
    logic                  resp_rd_ok_s;
    logic                  access_s;
    logic                  unused_prot_s;

    assign word_s   = PADDR[ADDR_WIDTH-1:SHIFT];
    assign access_s = PSEL & PENABLE;

`ifdef APB_SLV_MEM_PROT_CHK_EN
    assign unused_prot_s = PPROT[0] ^ PPROT[2];
`else
    assign unused_prot_s = ^PPROT;
`endif

    // Error classification of the live setup-phase address/attributes
    always_comb begin
        if (32'(word_s) >= 32'(DEPTH)) begin
            setup_cause_s = ERR_RANGE;
        end else if (PADDR[SHIFT-1:0] != {SHIFT{1'b0}}) begin
            setup_cause_s = ERR_ALIGN;
`ifdef APB_SLV_MEM_PROT_CHK_EN
        end else if (PPROT[1] && (32'(word_s) >= 32'(DEPTH / 2))) begin
            setup_cause_s = ERR_PROT;
`endif
        end else begin
            setup_cause_s = ERR_NONE;
        end
    end

    // Zero-wait responses come straight from the bus; otherwise from the latches
    assign rd_idx_s     = (state_r == IDLE) ? word_s[IDX_W-1:0] : idx_r;
    assign resp_rd_ok_s = (state_r == IDLE) ? (!PWRITE && (setup_cause_s == ERR_NONE))
                                            : (!write_r && (cause_r == ERR_NONE));

    // Next-state and response decode
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        pready_s  = pready_r;
        pslverr_s = pslverr_r;
        latch_s   = 1'b0;
        wr_en_s   = 1'b0;
        rd_en_s   = 1'b0;
        rd_clr_s  = 1'b0;
        case (state_r)
            IDLE: begin
                pready_s  = 1'b0;
                pslverr_s = 1'b0;
                if (PSEL && !PENABLE) begin
                    latch_s = 1'b1;
                    cnt_s   = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_s   = RESP;
                        pready_s  = 1'b1;
                        pslverr_s = (setup_cause_s != ERR_NONE);
                        rd_en_s   = resp_rd_ok_s;
                        rd_clr_s  = !resp_rd_ok_s;
                    end else begin
                        state_s = WAIT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (!access_s) begin
                    state_s   = IDLE;
                    cnt_s     = 4'd0;
                    pready_s  = 1'b0;
                    pslverr_s = 1'b0;
                end else if (cnt_r <= 4'd1) begin
                    // Registering PREADY as the count expires yields exactly WAIT_CYCLES wait states
                    state_s   = RESP;
                    cnt_s     = 4'd0;
                    pready_s  = 1'b1;
                    pslverr_s = (cause_r != ERR_NONE);
                    rd_en_s   = resp_rd_ok_s;
                    rd_clr_s  = !resp_rd_ok_s;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            RESP: begin
                state_s   = IDLE;
                cnt_s     = 4'd0;
                pready_s  = 1'b0;
                pslverr_s = 1'b0;
                if (access_s && write_r && (cause_r == ERR_NONE)) begin
                    wr_en_s = 1'b1;
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            default: begin
                state_s   = IDLE;
                cnt_s     = 4'd0;
                pready_s  = 1'b0;
                pslverr_s = 1'b0;
            end
        endcase
    end

    // FSM, counter and response flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= 4'd0;
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            pready_r  <= pready_s;
            pslverr_r <= pslverr_s;
        end
    end

    // Transfer attributes captured at the setup edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r   <= {IDX_W{1'b0}};
            write_r <= 1'b0;
            wdata_r <= {DATA_WIDTH{1'b0}};
            strb_r  <= {STRB_WIDTH{1'b0}};
            cause_r <= ERR_NONE;
        end else if (latch_s) begin
            idx_r   <= word_s[IDX_W-1:0];
            write_r <= PWRITE;
            wdata_r <= PWDATA;
            strb_r  <= PSTROB;
            cause_r <= setup_cause_s;
        end
    end

    apb_slv_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .STRB_WIDTH (STRB_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en_s),
        .wr_idx  (idx_r),
        .wr_data (wdata_r),
        .wr_strb (strb_r),
        .rd_en   (rd_en_s),
        .rd_clr  (rd_clr_s),
        .rd_idx  (rd_idx_s),
        .rd_data (PRDATA)
    );

    assign PREADY  = pready_r;
    assign PSLVERR = pslverr_r;

endmodule
